// File: rtl/sigmoid_pwl_pipe.sv
// sigmoid_pwl_pipe: pipelined shift/add PLAN sigmoid with valid/ready flow.
// Define SIGMOID_TANH_EN to add the per-sample in_mode tanh option.
module sigmoid_pwl_pipe #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
`ifdef SIGMOID_TANH_EN
  input  logic              in_mode,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
);

  localparam logic [DATA_W-1:0] ONE =
    {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_W;
  localparam logic [DATA_W-1:0] HALF = ONE >> 1;
  localparam logic [DATA_W-1:0] FIVE =
    {{(DATA_W-3){1'b0}}, 3'd5} << FRAC_W;
  localparam logic [DATA_W-1:0] K2375 =
    {{(DATA_W-5){1'b0}}, 5'd19} << (FRAC_W-3);
  localparam logic [DATA_W-1:0] K0625 =
    {{(DATA_W-3){1'b0}}, 3'd5} << (FRAC_W-3);
  localparam logic [DATA_W-1:0] K084 =
    {{(DATA_W-5){1'b0}}, 5'd27} << (FRAC_W-5);
  localparam logic [DATA_W-1:0] MAXP =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINV =
    {1'b1, {(DATA_W-1){1'b0}}};

  typedef struct packed {
    logic              v;
    logic              mode;
    logic [DATA_W-1:0] x;
    logic [TAG_W-1:0]  tag;
  } r0_t;

  typedef struct packed {
    logic              v;
    logic              mode;
    logic              sign;
    logic              ge5;
    logic              ge2;
    logic              ge1;
    logic [DATA_W-1:0] a;
    logic [TAG_W-1:0]  tag;
  } s1_t;

  typedef struct packed {
    logic              v;
    logic              mode;
    logic              sign;
    logic [DATA_W-1:0] p;
    logic [TAG_W-1:0]  tag;
  } s2_t;

  logic stall;
  logic mode_in;

  r0_t r0, r0_d;
  s1_t s1, s1_d;
  s2_t s2, s2_d;

  logic [DATA_W-1:0] abs_x;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] p;
  logic [DATA_W-1:0] ysig;
  logic [DATA_W-1:0] y;

`ifdef SIGMOID_TANH_EN
  assign mode_in = in_mode;
`else
  assign mode_in = 1'b0;
`endif

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    r0_d      = '0;
    r0_d.v    = in_valid;
    r0_d.mode = mode_in;
    r0_d.x    = in_data;
    r0_d.tag  = in_tag;
  end

  // |x| saturates for the most-negative input; tanh doubles it.
  always_comb begin
    abs_x = r0.x;
    if (r0.x == MINV)
      abs_x = MAXP;
    else if (r0.x[DATA_W-1])
      abs_x = -r0.x;
    a_in = abs_x;
    if (r0.mode)
      a_in = abs_x[DATA_W-2] ? MAXP : (abs_x << 1);
  end

  always_comb begin
    s1_d      = '0;
    s1_d.v    = r0.v;
    s1_d.mode = r0.mode;
    s1_d.sign = r0.x[DATA_W-1];
    s1_d.ge5  = a_in >= FIVE;
    s1_d.ge2  = a_in >= K2375;
    s1_d.ge1  = a_in >= ONE;
    s1_d.a    = a_in;
    s1_d.tag  = r0.tag;
  end

  always_comb begin
    p = (s1.a >> 2) + HALF;
    unique case (1'b1)
      s1.ge5:
        p = ONE;
      s1.ge2 & ~s1.ge5:
        p = (s1.a >> 5) + K084;
      s1.ge1 & ~s1.ge2:
        p = (s1.a >> 3) + K0625;
      default:
        p = (s1.a >> 2) + HALF;
    endcase
  end

  always_comb begin
    s2_d      = '0;
    s2_d.v    = s1.v;
    s2_d.mode = s1.mode;
    s2_d.sign = s1.sign;
    s2_d.p    = p;
    s2_d.tag  = s1.tag;
  end

  always_comb begin
    ysig = s2.sign ? (ONE - s2.p) : s2.p;
    y    = ysig;
    if (s2.mode)
      y = (ysig << 1) - ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r0        <= '0;
      s1        <= '0;
      s2        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (!stall) begin
      r0        <= r0_d;
      s1        <= s1_d;
      s2        <= s2_d;
      out_valid <= s2.v;
      out_data  <= y;
      out_tag   <= s2.tag;
    end
  end

endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
// tb_sigmoid_pwl_pipe: directed vectors for sigmoid_pwl_pipe,
// with an expected-result queue checked at the output.
module tb_sigmoid_pwl_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [7:0]  in_tag = '0;
  logic        in_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [7:0]  out_tag;

  int tests = 0;
  int fails = 0;

  logic [39:0] expq[$];
  bit          track = 1'b1;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [7:0]  prev_tag;

  sigmoid_pwl_pipe #(
    .DATA_W(32),
    .FRAC_W(16),
    .TAG_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_tag   (in_tag),
`ifdef SIGMOID_TANH_EN
    .in_mode  (in_mode),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             name, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [39:0] e;
    if (rst_n) begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        check("stall_data", out_data, prev_data);
        check("stall_tag", out_tag, prev_tag);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("spurious_out", out_valid, 1'b0);
        end else begin
          e = expq.pop_front();
          check("out_data", out_data, e[39:8]);
          check("out_tag", out_tag, e[7:0]);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // called at posedge+1; returns at the next posedge+1
  task automatic drive(input logic v, input logic [31:0] x,
                       input logic [7:0] t, input logic [31:0] e,
                       input logic m, input logic ordy,
                       output logic acc);
    in_valid  = v;
    in_data   = x;
    in_tag    = t;
    in_mode   = m;
    out_ready = ordy;
    @(negedge clk);
    acc = v && in_ready;
    if (acc && track)
      expq.push_back({e, t});
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] x, input logic [7:0] t,
                      input logic [31:0] e, input logic m);
    logic acc;
    drive(1'b1, x, t, e, m, 1'b1, acc);
    check("accept", acc, 1'b1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && expq.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain", expq.size(), 0);
  endtask

  task automatic latency(input logic [31:0] x, input logic [7:0] t,
                         input logic [31:0] e);
    send(x, t, e, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("latency_valid", out_valid, i == 3);
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] bx[10];
  logic [31:0] be[10];

  initial begin
    logic acc;
    int   idx;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_tag", out_tag, 8'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    latency(32'h0000_0000, 8'hAA, 32'h0000_8000);

    send(32'h0000_0000, 8'd1, 32'h0000_8000, 1'b0);
    send(32'h0000_8000, 8'd2, 32'h0000_A000, 1'b0);
    send(32'h0001_0000, 8'd3, 32'h0000_C000, 1'b0);
    send(32'hFFFF_0000, 8'd4, 32'h0000_4000, 1'b0);
    send(32'h0003_0000, 8'd5, 32'h0000_F000, 1'b0);
    send(32'h0005_0000, 8'd6, 32'h0001_0000, 1'b0);
    drain();

    send(32'h0006_0000, 8'h21, 32'h0001_0000, 1'b0);
    send(32'hFFFA_0000, 8'h22, 32'h0000_0000, 1'b0);
    send(32'h8000_0000, 8'h23, 32'h0000_0000, 1'b0);
    send(32'h7FFF_FFFF, 8'h24, 32'h0001_0000, 1'b0);
    send(32'h0002_6000, 8'h25, 32'h0000_EB00, 1'b0);
    send(32'h0002_5FFF, 8'h26, 32'h0000_EBFF, 1'b0);
    send(32'h0004_FFFF, 8'h27, 32'h0000_FFFF, 1'b0);
    send(32'h0000_FFFF, 8'h28, 32'h0000_BFFF, 1'b0);
    drain();

    bx = '{32'h0000_0000, 32'h0000_8000, 32'h0001_0000,
           32'hFFFF_0000, 32'h0003_0000, 32'h0005_0000,
           32'h0006_0000, 32'hFFFA_0000, 32'h8000_0000,
           32'h0002_6000};
    be = '{32'h0000_8000, 32'h0000_A000, 32'h0000_C000,
           32'h0000_4000, 32'h0000_F000, 32'h0001_0000,
           32'h0001_0000, 32'h0000_0000, 32'h0000_0000,
           32'h0000_EB00};
    idx = 0;
    for (int c = 0;
         c < 200 && (idx < 10 || expq.size() != 0); c++) begin
      drive(idx < 10, bx[idx < 10 ? idx : 0],
            8'(8'h40 + idx), be[idx < 10 ? idx : 0],
            1'b0, (c % 3) == 0, acc);
      if (acc)
        idx++;
    end
    check("bp_accepted", idx, 10);
    drain();

    track = 1'b0;
    send(32'h0001_0000, 8'h61, 32'h0, 1'b0);
    send(32'h0002_0000, 8'h62, 32'h0, 1'b0);
    send(32'h0003_0000, 8'h63, 32'h0, 1'b0);
    track = 1'b1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_flush", out_valid, 1'b0);
    @(posedge clk);
    #1;
    repeat (6) @(posedge clk);
    #1;
    latency(32'h0000_0000, 8'h77, 32'h0000_8000);
    drain();

`ifdef SIGMOID_TANH_EN
    send(32'h0000_0000, 8'h81, 32'h0000_0000, 1'b1);
    send(32'h0000_8000, 8'h82, 32'h0000_8000, 1'b1);
    send(32'hFFFF_8000, 8'h83, 32'hFFFF_8000, 1'b1);
    send(32'h0004_0000, 8'h84, 32'h0001_0000, 1'b1);
    send(32'h7FFF_FFFF, 8'h85, 32'h0001_0000, 1'b1);
    send(32'h8000_0000, 8'h86, 32'hFFFF_0000, 1'b1);
    send(32'h0000_8000, 8'h87, 32'h0000_A000, 1'b0);
    send(32'h0000_8000, 8'h88, 32'h0000_8000, 1'b1);
    send(32'hFFFF_8000, 8'h89, 32'h0000_6000, 1'b0);
    send(32'hFFFF_8000, 8'h8A, 32'hFFFF_8000, 1'b1);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
